// File: rtl/fnd_scan_driver_pkg.sv
// Shared constants for the FND scan driver: segment fonts, FSM encoding, datapath widths.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active low.
package fnd_scan_driver_pkg;

  localparam int BIN_W        = 14;
  localparam int BCD_W        = 16;
  localparam int NUM_DIGITS   = 4;
  localparam int SHIFT_CYCLES = BIN_W;

  localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_OVF   = 2'd3
  } conv_state_t;

  function automatic logic [7:0] font_of(input logic [3:0] digit);
    case (digit)
      4'd0:    font_of = FONT_0;
      4'd1:    font_of = FONT_1;
      4'd2:    font_of = FONT_2;
      4'd3:    font_of = FONT_3;
      4'd4:    font_of = FONT_4;
      4'd5:    font_of = FONT_5;
      4'd6:    font_of = FONT_6;
      4'd7:    font_of = FONT_7;
      4'd8:    font_of = FONT_8;
      4'd9:    font_of = FONT_9;
      default: font_of = FONT_BLANK;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [3:0] nib;
    dabble_adjust = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      dabble_adjust[4*i +: 4] = nib;
    end
  endfunction

endpackage

// File: rtl/fnd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, 14 shifts then a one-cycle DONE.
// o_bcd is only meaningful while o_done is high; the caller latches it then.
module bin2bcd_seq
  import fnd_scan_driver_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [BIN_W-1:0]  i_bin,
  output logic              o_busy,
  output logic              o_done,
  output logic [BCD_W-1:0]  o_bcd,
  output conv_state_t       o_state
);

  localparam logic [3:0] LAST_SHIFT = 4'(SHIFT_CYCLES - 1);

  conv_state_t       r_state;
  conv_state_t       w_next_state;
  logic [3:0]        r_cnt;
  logic [BCD_W-1:0]  r_bcd;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  w_bcd_adj;

  assign w_bcd_adj = dabble_adjust(r_bcd);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_bcd <= '0;
            r_bin <= i_bin;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_SHIFT) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = (r_state == ST_DONE);
  assign o_bcd   = r_bcd;
  assign o_state = r_state;

endmodule

// File: rtl/fnd_scan_driver.sv
// Binary-to-FND display stage: range check, BCD conversion, atomic display register,
// and a time-multiplexed scan of four common-anode digits.
module fnd_scan_driver
  import fnd_scan_driver_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter bit LZB     = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [BIN_W-1:0]  i_value,
  input  logic              i_load,
  output logic              o_busy,
  output logic [3:0]        o_fnd_digit,
  output logic [7:0]        o_fnd_font
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic              w_conv_busy;
  logic              w_conv_done;
  logic [BCD_W-1:0]  w_conv_bcd;
  conv_state_t       w_conv_state;
  conv_state_t       w_state;

  logic              w_accept;
  logic              w_start;
  logic              w_ovf_hit;

  logic              r_ovf;
  logic              r_dash;
  logic [BCD_W-1:0]  r_disp;
  logic [PW-1:0]     r_presc;
  logic [1:0]        r_idx;

  logic [3:0]        w_digit;
  logic              w_lead_zero;
  logic [7:0]        w_font;

  // Loads arriving while busy are dropped, never queued.
  assign w_accept  = i_load && !w_conv_busy && !r_ovf;
  assign w_start   = w_accept && (i_value <= MAX_VALUE);
  assign w_ovf_hit = w_accept && (i_value > MAX_VALUE);

  bin2bcd_seq u_bin2bcd (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (w_start),
    .i_bin     (i_value),
    .o_busy    (w_conv_busy),
    .o_done    (w_conv_done),
    .o_bcd     (w_conv_bcd),
    .o_state   (w_conv_state)
  );

  // Overall state seen from outside: the converter's FSM, or the one-cycle OVF step.
  assign w_state = r_ovf ? ST_OVF : w_conv_state;
  assign o_busy  = (w_state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ovf  <= 1'b0;
      r_dash <= 1'b0;
      r_disp <= '0;
    end else begin
      r_ovf <= w_ovf_hit;
      if (r_ovf) begin
        r_dash <= 1'b1;
      end else if (w_conv_done) begin
        r_disp <= w_conv_bcd;
        r_dash <= 1'b0;
      end
    end
  end

  assign w_digit = r_disp[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_lead_zero = 1'b0;
    case (r_idx)
      2'd1:    w_lead_zero = (r_disp[15:4]  == 12'd0);
      2'd2:    w_lead_zero = (r_disp[15:8]  == 8'd0);
      2'd3:    w_lead_zero = (r_disp[15:12] == 4'd0);
      default: w_lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    w_font = font_of(w_digit);
    if (r_dash)                 w_font = FONT_DASH;
    else if (LZB && w_lead_zero) w_font = FONT_BLANK;
  end

  // Outputs lag the scan index by one clock so the pins change cleanly on a register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_presc     <= '0;
      r_idx       <= 2'd0;
      o_fnd_digit <= 4'hF;
      o_fnd_font  <= FONT_BLANK;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      o_fnd_digit <= ~(4'b0001 << r_idx);
      o_fnd_font  <= w_font;
    end
  end

endmodule
